// File: rtl/branch_history_ctrl.sv
// Branch predictor controller: 2-bit saturating counter table indexed by PC bits,
// mispredict flush/pc-select generation, table-clear sweep and mispredict statistics.
//
// state | meaning
// IDLE  | normal predict/train operation
// CLEAR | sweeping table entries back to INIT_CNT, one per cycle
module branch_history_ctrl #(
  parameter int unsigned IDX_W    = 4,
  parameter logic [1:0]  INIT_CNT = 2'b01,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid,
  input  logic [IDX_W-1:0] pred_idx,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic [IDX_W-1:0] res_idx,
  input  logic             res_taken,
  input  logic             res_pred,
  output logic             flush,
  output logic             pc_sel,
  input  logic             clr_req,
  output logic             busy,
  output logic [CNT_W-1:0] mispred
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [DEPTH-1:0][1:0]     tbl_q, tbl_d;
  logic                      flush_q, flush_d;
  logic                      pc_sel_q, pc_sel_d;
  logic [CNT_W-1:0]          mispred_q, mispred_d;
  logic                      mismatch;

  assign mismatch = res_valid & (res_taken ^ res_pred);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      tbl_q     <= {DEPTH{INIT_CNT}};
      flush_q   <= 1'b0;
      pc_sel_q  <= 1'b0;
      mispred_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      tbl_q     <= tbl_d;
      flush_q   <= flush_d;
      pc_sel_q  <= pc_sel_d;
      mispred_q <= mispred_d;
    end
  end

  // A clear request mid-sweep still writes the current entry, then restarts at 0.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        if (clr_req) begin
          ptr_d = '0;
        end else if (ptr_q == '1) begin
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Training is dropped while sweeping so the sweep never races an update.
  always_comb begin
    tbl_d = tbl_q;
    if (state_q == CLEAR) begin
      tbl_d[ptr_q] = INIT_CNT;
    end else if (res_valid) begin
      if (res_taken && (tbl_q[res_idx] != 2'b11)) begin
        tbl_d[res_idx] = tbl_q[res_idx] + 2'd1;
      end else if (!res_taken && (tbl_q[res_idx] != 2'b00)) begin
        tbl_d[res_idx] = tbl_q[res_idx] - 2'd1;
      end
    end
  end

  always_comb begin
    flush_d   = mismatch;
    pc_sel_d  = mismatch & res_taken;
    mispred_d = mispred_q;
    if (mismatch && (mispred_q != '1)) begin
      mispred_d = mispred_q + 1'b1;
    end
  end

  assign pred_taken = pred_valid & (state_q == IDLE) & tbl_q[pred_idx][1];
  assign flush      = flush_q;
  assign pc_sel     = pc_sel_q;
  assign busy       = (state_q == CLEAR);
  assign mispred    = mispred_q;

endmodule

// File: tb/tb_branch_history_ctrl.sv
// Randomized and directed bench for branch_history_ctrl against a behavioural
// counter-table / clear-sweep model.
module tb_branch_history_ctrl;

  localparam int IDX_W   = 4;
  localparam int DEPTH   = 16;
  localparam int CNT_W   = 12;
  localparam int MIS_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             pred_valid;
  logic [IDX_W-1:0] pred_idx;
  logic             pred_taken;
  logic             res_valid;
  logic [IDX_W-1:0] res_idx;
  logic             res_taken;
  logic             res_pred;
  logic             flush;
  logic             pc_sel;
  logic             clr_req;
  logic             busy;
  logic [CNT_W-1:0] mispred;

  int n_chk;
  int n_bad;

  int m_tbl [DEPTH];
  int m_left;
  int m_mis;

  branch_history_ctrl #(
    .IDX_W   (IDX_W),
    .INIT_CNT(2'b01),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pred_valid(pred_valid),
    .pred_idx  (pred_idx),
    .pred_taken(pred_taken),
    .res_valid (res_valid),
    .res_idx   (res_idx),
    .res_taken (res_taken),
    .res_pred  (res_pred),
    .flush     (flush),
    .pc_sel    (pc_sel),
    .clr_req   (clr_req),
    .busy      (busy),
    .mispred   (mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = 1;
    m_left = 0;
    m_mis  = 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    pred_valid = 0; pred_idx = 0; res_valid = 0; res_idx = 0;
    res_taken = 0; res_pred = 0; clr_req = 0;
    rst_n = 0;
    model_reset();
    #1;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_mispred", 32'(mispred), 0);
    check_eq("rst_flush", 32'(flush), 0);
    check_eq("rst_pc_sel", 32'(pc_sel), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  // One clock: drive at negedge, check lookup, advance model at the edge, check registers.
  task automatic cycle(input logic pv, input int pi, input logic rv, input int ri,
                       input logic rt, input logic rp, input logic cr);
    logic exp_pred;
    logic mis;
    @(negedge clk);
    pred_valid = pv; pred_idx = IDX_W'(pi);
    res_valid = rv; res_idx = IDX_W'(ri); res_taken = rt; res_pred = rp;
    clr_req = cr;
    #1;
    exp_pred = pv && (m_left == 0) && (m_tbl[pi] >= 2);
    check_eq("pred_taken", 32'(pred_taken), 32'(exp_pred));
    @(posedge clk);
    mis = rv && (rt != rp);
    if (mis && m_mis < MIS_MAX) m_mis++;
    if (rv && m_left == 0) begin
      if (rt) m_tbl[ri] = (m_tbl[ri] == 3) ? 3 : m_tbl[ri] + 1;
      else    m_tbl[ri] = (m_tbl[ri] == 0) ? 0 : m_tbl[ri] - 1;
    end
    if (m_left > 0) begin
      m_tbl[DEPTH - m_left] = 1;
      m_left = cr ? DEPTH : m_left - 1;
    end else if (cr) begin
      m_left = DEPTH;
    end
    #1;
    check_eq("flush", 32'(flush), 32'(mis));
    check_eq("pc_sel", 32'(pc_sel), 32'(mis && rt));
    check_eq("busy", 32'(busy), 32'(m_left > 0));
    check_eq("mispred", 32'(mispred), 32'(m_mis));
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Each entry must predict not-taken, and one taken outcome must flip it (01 -> 10).
  task automatic verify_init();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, i, 1, i, 1, 0, 0);
      cycle(1, i, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    int n;
    n_chk = 0;
    n_bad = 0;
    rst_n = 1;
    do_reset();

    // reset contents
    for (int i = 0; i < DEPTH; i++) cycle(1, i, 0, 0, 0, 0, 0);
    verify_init();
    do_reset();

    // training to strongly taken, with mispredict flushes
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 3, 1, 0, 0);
    cycle(1, 3, 0, 0, 0, 0, 0);
    check_eq("t2_mispred", 32'(mispred), 3);

    // saturation at 00 with correct predictions
    for (int k = 0; k < 4; k++) cycle(1, 5, 1, 5, 0, 0, 0);
    cycle(0, 0, 1, 5, 1, 1, 0);
    cycle(1, 5, 0, 0, 0, 0, 0);
    check_eq("t3_mispred", 32'(mispred), 3);

    // same-cycle lookup sees pre-update value
    cycle(1, 2, 1, 2, 1, 1, 0);
    cycle(1, 2, 0, 0, 0, 0, 0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 49) == 0));
    end
    while (m_left > 0) idle();

    // clear sweep length, mid-sweep resolution
    for (int i = 0; i < DEPTH; i++) for (int k = 0; k < 3; k++) cycle(0, 0, 1, i, 1, 1, 0);
    cycle(1, 7, 0, 0, 0, 0, 1);
    n = busy ? 1 : 0;
    for (int k = 1; k < 40 && busy; k++) begin
      if (k == 5) cycle(1, 0, 1, 0, 0, 1, 0);
      else cycle(1, k % DEPTH, 0, 0, 0, 0, 0);
      if (busy) n++;
    end
    check_eq("clr_len", 32'(n), 16);
    verify_init();

    // restart mid-sweep
    cycle(0, 0, 0, 0, 0, 0, 1);
    n = busy ? 1 : 0;
    for (int k = 1; k < 60 && busy; k++) begin
      cycle(0, 0, 0, 0, 0, 0, k == 8);
      if (busy) n++;
    end
    check_eq("clr_restart_len", 32'(n), 24);

    // mispred saturation
    do_reset();
    for (int k = 0; k < MIS_MAX - 1; k++) cycle(0, 0, 1, k % DEPTH, k[0], ~k[0], 0);
    check_eq("mis_max_m1", 32'(mispred), 32'(MIS_MAX - 1));
    cycle(0, 0, 1, 1, 1, 0, 0);
    cycle(0, 0, 1, 2, 0, 1, 0);
    check_eq("mis_sat", 32'(mispred), 32'(MIS_MAX));

    // reset mid-sweep
    for (int i = 0; i < DEPTH; i++) for (int k = 0; k < 3; k++) cycle(0, 0, 1, i, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) idle();
    check_eq("mid_busy", 32'(busy), 1);
    do_reset();
    verify_init();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
